fifo_wr_arbiter: RTL and testbench

//  Shares the single write port of the dual-clock FIFO among NUM_REQ requesters in the write clock domain.
//  Per-requester valid/ready handshake; round-robin grant with packet lock (held until last beat or MAX_BURST beats).

---
 rtl/fifo_wr_arbiter_pkg.sv | 23 ++
 rtl/fifo_wr_arbiter_rr_arbiter.sv | 47 ++++
 rtl/fifo_wr_arbiter.sv | 109 ++++++++++
 tb/tb_fifo_wr_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_wr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_arb_pkg
//  Purpose  : Shared types and helpers for the FIFO write-port arbiter.
//             arb_state_t - arbiter FSM states (IDLE / BURST)
//             idx_width() - tag/index width for n requesters (clog2, min 1)
//  Revision : 1.0 - initial release
// ============================================================================
package fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_t;

  // A single requester still needs a one-bit index so ports never collapse
  // to zero width.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_wr_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Purpose  : Combinational round-robin pick. Returns the first set request
//             at or after ptr, wrapping modulo N.
//  Ports    : req [N]  - request vector
//             ptr [IW] - highest-priority position (must be < N)
//             any      - at least one request set
//             idx [IW] - selected index (valid when any = 1)
//  Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          any,
  output logic [IW-1:0] idx
);

  logic [2*N-1:0] w_dbl;
  logic [N-1:0]   w_rot;
  logic [IW-1:0]  w_enc;
  logic [IW:0]    w_sum;

  // Rotate right by ptr so position ptr lands on bit 0.
  assign w_dbl = {req, req} >> ptr;
  assign w_rot = w_dbl[N-1:0];

  // Lowest set bit of the rotated vector wins.
  always_comb begin
    w_enc = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_rot[k]) w_enc = IW'(k);
    end
  end

  // Rotate back: (ptr + enc) mod N, both operands already < N.
  assign w_sum = {1'b0, ptr} + {1'b0, w_enc};
  assign idx   = (w_sum >= (IW+1)'(N)) ? IW'(w_sum - (IW+1)'(N)) : w_sum[IW-1:0];
  assign any   = |req;

endmodule
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_wr_arbiter
//  Purpose  : Shares the FIFO write port among NUM_REQ requesters with
//             round-robin grant and packet lock (held until last beat or
//             MAX_BURST beats). Each accepted beat is written as
//             {grant_id, data}. An idle arbitration cycle follows every grant.
//  Ports    : clk, reset_n (async, active low)
//             req_valid/req_data/req_last [NUM_REQ] in, req_ready [NUM_REQ] out
//             fifo_wen, fifo_wdata out; fifo_wfull in
//             grant_id (current owner), busy (grant held)
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 8,
  parameter  int MAX_BURST  = 4,
  localparam int IDX_W      = idx_width(NUM_REQ)
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic [NUM_REQ-1:0]                  req_valid,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_data,
  input  logic [NUM_REQ-1:0]                  req_last,
  output logic [NUM_REQ-1:0]                  req_ready,
  output logic                                fifo_wen,
  output logic [IDX_W+DATA_WIDTH-1:0]         fifo_wdata,
  input  logic                                fifo_wfull,
  output logic [IDX_W-1:0]                    grant_id,
  output logic                                busy
);

  localparam int                 c_CNT_W      = $clog2(MAX_BURST + 1);
  localparam logic [c_CNT_W-1:0] c_LAST_CNT   = c_CNT_W'(MAX_BURST - 1);
  localparam logic [IDX_W-1:0]   c_LAST_GRANT = IDX_W'(NUM_REQ - 1);

  arb_state_t          r_state;
  logic [IDX_W-1:0]    r_grant_id;
  logic [IDX_W-1:0]    r_rr_ptr;
  logic [c_CNT_W-1:0]  r_beat_cnt;

  logic                w_any;
  logic [IDX_W-1:0]    w_idx;
  logic                w_accept;
  logic                w_terminate;

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr_arbiter (
    .req (req_valid),
    .ptr (r_rr_ptr),
    .any (w_any),
    .idx (w_idx)
  );

  assign busy     = (r_state == ARB_BURST);
  assign grant_id = r_grant_id;

  // Handshake and FIFO write happen in the same cycle: no pipeline stage.
  assign w_accept    = busy & req_valid[r_grant_id] & ~fifo_wfull;
  assign w_terminate = req_last[r_grant_id] | (r_beat_cnt == c_LAST_CNT);
  assign fifo_wen    = w_accept;

  // Forced to zero outside a grant so the bus is quiet while idle/in reset.
  assign fifo_wdata = busy ? {r_grant_id, req_data[r_grant_id]} : '0;

  always_comb begin
    req_ready = '0;
    if (busy && !fifo_wfull) req_ready[r_grant_id] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ARB_IDLE;
      r_grant_id <= '0;
      r_rr_ptr   <= '0;
      r_beat_cnt <= '0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          // Requests are only sampled here; non-owners are ignored in BURST.
          if (w_any) begin
            r_grant_id <= w_idx;
            r_beat_cnt <= '0;
            r_state    <= ARB_BURST;
          end
        end
        ARB_BURST: begin
          // Valid gaps and full stalls simply wait: the grant is packet-locked.
          if (w_accept) begin
            if (w_terminate) begin
              r_state    <= ARB_IDLE;
              r_beat_cnt <= '0;
              r_rr_ptr   <= (r_grant_id == c_LAST_GRANT) ? '0
                                                         : r_grant_id + IDX_W'(1);
            end else begin
              r_beat_cnt <= r_beat_cnt + c_CNT_W'(1);
            end
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_wr_arbiter
//  Purpose  : Self-checking bench for fifo_wr_arbiter. Requester models feed
//             beats from per-source queues; expected FIFO words are queued in
//             hand-computed order and a monitor pops/compares on each write.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int DATA_WIDTH = 8;
  localparam int MAX_BURST  = 4;
  localparam int IDX_W      = 2;

  logic                               clk = 1'b0;
  logic                               reset_n;
  logic [NUM_REQ-1:0]                 req_valid;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]                 req_last;
  logic [NUM_REQ-1:0]                 req_ready;
  logic                               fifo_wen;
  logic [IDX_W+DATA_WIDTH-1:0]        fifo_wdata;
  logic                               fifo_wfull;
  logic [IDX_W-1:0]                   grant_id;
  logic                               busy;

  fifo_wr_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .DATA_WIDTH (DATA_WIDTH),
    .MAX_BURST  (MAX_BURST)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .fifo_wen   (fifo_wen),
    .fifo_wdata (fifo_wdata),
    .fifo_wfull (fifo_wfull),
    .grant_id   (grant_id),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_acc    = 0;

  logic [9:0]         exp_q [$];
  logic [8:0]         bq [NUM_REQ][$];   // {last, data}
  logic [NUM_REQ-1:0] hold;
  logic [9:0]         mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Beat k of source src carries data src*16+k.
  task automatic load(input int src, input int k0, input int n, input int last_k);
    for (int k = k0; k < k0 + n; k++)
      bq[src].push_back({(k == last_k), 8'(src * 16 + k)});
  endtask

  task automatic expw(input int src, input int k);
    exp_q.push_back({2'(src), 8'(src * 16 + k)});
  endtask

  task automatic apply();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (bq[i].size() > 0 && !hold[i]) begin
        req_valid[i] = 1'b1;
        req_data[i]  = bq[i][0][7:0];
        req_last[i]  = bq[i][0][8];
      end else begin
        req_valid[i] = 1'b0;
        req_data[i]  = '0;
        req_last[i]  = 1'b0;
      end
    end
  endtask

  // One clock: drive at the falling edge, record handshakes just before the
  // rising edge, return at the next falling edge.
  task automatic cycle();
    apply();
    #3;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        void'(bq[i].pop_front());
        n_acc++;
      end
    end
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) cycle();
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    #2;
    if (reset_n && fifo_wen) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_write: got %0h required no write", fifo_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        chk("fifo_word", 32'(fifo_wdata), 32'(mon_e));
      end
      chk("write_while_full", 32'(fifo_wfull), 32'd0);
    end
    if (req_ready != '0) chk("ready_onehot", $countones(req_ready), 32'd1);
  end

  int acc0;

  initial begin
    reset_n    = 1'b0;
    fifo_wfull = 1'b0;
    hold       = '0;
    req_valid  = '0;
    req_data   = '0;
    req_last   = '0;

    // Reset with every requester valid; round-robin with last on each beat
    for (int i = 0; i < NUM_REQ; i++) load(i, 0, 2, -1);
    for (int i = 0; i < NUM_REQ; i++) begin
      bq[i][0][8] = 1'b1;
      bq[i][1][8] = 1'b1;
    end
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NUM_REQ; i++) expw(i, r);

    for (int c = 0; c < 3; c++) begin
      cycle();
      chk("reset_ready", 32'(req_ready), 32'd0);
      chk("reset_wen", 32'(fifo_wen), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
    end
    reset_n = 1'b1;
    acc0 = n_acc;
    cycle();
    chk("first_grant_busy", 32'(busy), 32'd1);
    chk("first_grant_id", 32'(grant_id), 32'd0);
    run(15);
    chk("rr_writes_in_16", 32'(n_acc - acc0), 32'd8);

    // Burst cap: req0 six beats (last on 6th), req1 one beat
    load(0, 0, 6, 5);
    load(1, 0, 1, 0);
    expw(0, 0); expw(0, 1); expw(0, 2); expw(0, 3);
    expw(1, 0);
    expw(0, 4); expw(0, 5);
    run(12);

    // Full stall mid-burst of req2 (cap-terminated), req0 waiting
    load(2, 0, 5, 4);
    load(0, 0, 1, 0);
    expw(2, 0); expw(2, 1); expw(2, 2); expw(2, 3);
    expw(0, 0);
    expw(2, 4);
    run(3);
    fifo_wfull = 1'b1;
    for (int c = 0; c < 3; c++) begin
      cycle();
      chk("stall_ready", 32'(req_ready), 32'd0);
      chk("stall_wen", 32'(fifo_wen), 32'd0);
      chk("stall_grant", 32'(grant_id), 32'd2);
      chk("stall_busy", 32'(busy), 32'd1);
    end
    fifo_wfull = 1'b0;
    run(8);

    // Valid gap on owner req1 while req3 waits
    load(1, 0, 3, 2);
    expw(1, 0); expw(1, 1); expw(1, 2);
    expw(3, 0);
    run(2);
    load(3, 0, 1, 0);
    hold[1] = 1'b1;
    for (int c = 0; c < 2; c++) begin
      cycle();
      chk("gap_grant", 32'(grant_id), 32'd1);
      chk("gap_busy", 32'(busy), 32'd1);
      chk("gap_ready", 32'(req_ready), 32'b0010);
    end
    hold[1] = 1'b0;
    run(6);

    // Async reset mid-burst: move rr_ptr to 2, grant req3, reset between edges
    load(1, 0, 1, 0);
    expw(1, 0);
    run(2);
    load(3, 0, 3, 2);
    load(0, 0, 1, 0);
    expw(3, 0);
    expw(0, 0);
    expw(3, 1); expw(3, 2);
    run(2);
    chk("pre_reset_grant", 32'(grant_id), 32'd3);
    apply();
    #1 reset_n = 1'b0;
    #1;
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_ready", 32'(req_ready), 32'd0);
    chk("async_wen", 32'(fifo_wen), 32'd0);
    chk("async_wdata", 32'(fifo_wdata), 32'd0);
    chk("async_grant", 32'(grant_id), 32'd0);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("post_reset_grant", 32'(grant_id), 32'd0);
    chk("post_reset_busy", 32'(busy), 32'd1);
    run(6);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < NUM_REQ; i++) chk("source_drained", 32'(bq[i].size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
